// File: rtl/msdap_frame_rx_fifo.sv
// MSDAP serial frame receiver: CH-channel MSB-first deserialiser
// feeding a first-word-fall-through frame FIFO with zero-run sleep.
module msdap_frame_rx_fifo #(
  parameter  int CH       = 2,
  parameter  int W        = 16,
  parameter  int DEPTH    = 4,
  parameter  int ZERO_RUN = 800,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              Frame,
  input  logic              bit_en,
  input  logic [CH-1:0]     Din,
  output logic              InReady,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [CH*W-1:0]   rd_data,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow,
  output logic              framing_err,
  output logic              sleep
);

  localparam int BW = (W > 2) ? $clog2(W) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ZW = $clog2(ZERO_RUN + 1);
  localparam int FW = CH * W;

  localparam logic [BW-1:0] BIT_TOP = BW'(W - 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_END = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [ZW-1:0] Z_MAX   = ZW'(ZERO_RUN);
  localparam logic [ZW-1:0] Z_ONE   = ZW'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [FW-1:0]   sh_q, sh_d;
  logic [FW-1:0]   word, fresh;
  logic            done, ferr_set;

  logic [FW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [FW-1:0]   head_q, head_d;
  logic            rdy_q, ovf_q, ferr_q, sleep_q;
  logic [ZW-1:0]   zcnt_q, zcnt_d;

  logic            zero, push_req, pop, push, full, fill_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_END) ? '0 : p + PTR_ONE;
  endfunction

  // word: completed shift incl. this bit; fresh: this bit as a new MSB
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      word[c*W +: W]  = {sh_q[c*W +: W-1], Din[c]};
      fresh[c*W +: W] = {{(W-1){1'b0}}, Din[c]};
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    done     = 1'b0;
    ferr_set = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (Frame) begin
            sh_d     = fresh;
            bitcnt_d = BIT_TOP;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (Frame) begin
            ferr_set = 1'b1;
            sh_d     = fresh;
            bitcnt_d = BIT_TOP;
          end else begin
            sh_d = word;
            if (bitcnt_q == '0) begin
              done    = 1'b1;
              state_d = IDLE;
            end else begin
              bitcnt_d = bitcnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign zero     = ~|word;
  assign push_req = done && !(sleep_q && zero);
  assign pop      = rd_en && (count_q != '0);
  assign full     = (count_q == CNT_MAX);
  assign push     = push_req && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_ONE;
    else if (!push && pop) count_d = count_q - CNT_ONE;
  end

  assign wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
  assign rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;

  // FIFO drains to empty this edge, so the incoming word becomes head
  assign fill_head = push && (count_q == (pop ? CNT_ONE : '0));

  always_comb begin
    head_d = head_q;
    if (fill_head) head_d = word;
    else if (count_d != '0) head_d = mem_q[rptr_d];
  end

  always_comb begin
    zcnt_d = zcnt_q;
    if (done) begin
      if (!zero) zcnt_d = '0;
      else if (zcnt_q != Z_MAX) zcnt_d = zcnt_q + Z_ONE;
    end
  end

  always_ff @(posedge Sclk) begin
    if (push) mem_q[wptr_q] <= word;
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sh_q     <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      head_q   <= '0;
      rdy_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      zcnt_q   <= '0;
      sleep_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      rdy_q    <= (count_q < CNT_MAX);
      ovf_q    <= ovf_q | (push_req && !push);
      ferr_q   <= ferr_q | ferr_set;
      zcnt_q   <= zcnt_d;
      sleep_q  <= (zcnt_d == Z_MAX);
    end
  end

  assign InReady     = rdy_q;
  assign rd_valid    = (count_q != '0);
  assign rd_data     = head_q;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign framing_err = ferr_q;
  assign sleep       = sleep_q;

endmodule

// File: tb/tb_msdap_frame_rx_fifo.sv
// Directed bench for msdap_frame_rx_fifo (CH=2, W=16, DEPTH=4,
// ZERO_RUN=3) with a queue scoreboard of expected FIFO entries.
module tb_msdap_frame_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        ben = 1'b0;
  logic        rd_en = 1'b0;
  logic [1:0]  din = '0;
  logic        in_ready, rd_valid, ovf, ferr, slp;
  logic [31:0] rd_data;
  logic [2:0]  cnt;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  int          mc = 0;
  int          m_z = 0;
  bit          m_ovf = 0, m_ferr = 0, m_sleep = 0, m_mid = 0;

  msdap_frame_rx_fifo #(
    .CH(2), .W(16), .DEPTH(4), .ZERO_RUN(3)
  ) dut (
    .Sclk(clk), .Reset_n(rst_n), .Frame(frame), .bit_en(ben),
    .Din(din), .InReady(in_ready), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(cnt),
    .overflow(ovf), .framing_err(ferr), .sleep(slp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mc = 0; m_z = 0;
    m_ovf = 0; m_ferr = 0; m_sleep = 0; m_mid = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(cnt), 32'(mc));
    chk({tag, ".valid"}, 32'(rd_valid), 32'(mc != 0));
    chk({tag, ".ready"}, 32'(in_ready), 32'(mc < 4));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".ferr"}, 32'(ferr), 32'(m_ferr));
    chk({tag, ".sleep"}, 32'(slp), 32'(m_sleep));
    if (q.size() != 0) chk({tag, ".head"}, rd_data, q[0]);
  endtask

  task automatic send_bit(input logic fr, input logic [1:0] d);
    ben = 1'b1; frame = fr; din = d;
    @(posedge clk); #1;
    ben = 1'b0; frame = 1'b0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic partial(input int n, input logic [15:0] v);
    for (int i = 15; i > 15 - n; i--) send_bit(i == 15, {v[i], v[i]});
    m_mid = 1;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input bit pop_last);
    bit popped, zero;
    if (m_mid) m_ferr = 1;
    m_mid = 0;
    popped = pop_last && (mc > 0);
    zero = (l == 16'h0) && (r == 16'h0);
    for (int i = 15; i >= 0; i--) begin
      if (i == 0 && pop_last) begin
        if (popped) chk("pop_at_last_bit", rd_data, q[0]);
        rd_en = 1'b1;
      end
      send_bit(i == 15, {r[i], l[i]});
    end
    if (popped) begin
      void'(q.pop_front());
      mc--;
    end
    if (!(m_sleep && zero)) begin
      if (mc < 4) begin
        q.push_back({r, l});
        mc++;
      end else m_ovf = 1;
    end
    if (!zero) m_z = 0;
    else if (m_z < 3) m_z++;
    m_sleep = (m_z == 3);
  endtask

  task automatic pop_one(input string tag);
    chk({tag, ".valid"}, 32'(rd_valid), 32'h1);
    chk({tag, ".data"}, rd_data, q[0]);
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    void'(q.pop_front());
    mc--;
  endtask

  task automatic drain(input string tag);
    while (mc > 0) pop_one(tag);
    chk({tag, ".empty"}, 32'(rd_valid), 32'h0);
    chk({tag, ".cnt0"}, 32'(cnt), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ben = 1'b0; frame = 1'b0; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset values
    #1;
    chk("rst.ready", 32'(in_ready), 32'h0);
    chk("rst.valid", 32'(rd_valid), 32'h0);
    chk("rst.data", rd_data, 32'h0);
    chk("rst.count", 32'(cnt), 32'h0);
    chk("rst.flags", {29'h0, ovf, ferr, slp}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.ready_up", 32'(in_ready), 32'h1);

    // single stereo frame
    send_frame(16'h1234, 16'hABCD, 0);
    chk("t1.data", rd_data, 32'hABCD_1234);
    check_state("t1");
    pop_one("t1.pop");
    chk("t1.hold", rd_data, 32'hABCD_1234);
    chk("t1.empty", 32'(rd_valid), 32'h0);

    // overflow: 5 frames, no reads
    for (int k = 1; k <= 5; k++) begin
      send_frame(16'(k), 16'(k), 0);
      check_state("t2.fill");
    end
    chk("t2.ovf", 32'(ovf), 32'h1);
    chk("t2.ready", 32'(in_ready), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      chk("t2.order", rd_data, {16'(k), 16'(k)});
      pop_one("t2.pop");
    end
    chk("t2.empty", 32'(rd_valid), 32'h0);

    // full FIFO with a pop on the last bit
    do_reset();
    for (int k = 0; k < 4; k++) send_frame(16'h11 + 16'(k), 16'h8000, 0);
    send_frame(16'h0055, 16'h00AA, 1);
    check_state("t3");
    chk("t3.count", 32'(cnt), 32'h4);
    chk("t3.noovf", 32'(ovf), 32'h0);
    drain("t3.drain");

    // framing error mid-word, then clean word
    do_reset();
    partial(7, 16'hFFFF);
    send_frame(16'h5A5A, 16'h5A5A, 0);
    chk("t4.ferr", 32'(ferr), 32'h1);
    chk("t4.count", 32'(cnt), 32'h1);
    chk("t4.data", rd_data, 32'h5A5A_5A5A);
    check_state("t4");
    drain("t4.drain");

    // zero-run sleep with ZERO_RUN=3
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send_frame(16'h0, 16'h0, 0);
      check_state("t5.zero");
    end
    chk("t5.sleep", 32'(slp), 32'h1);
    send_frame(16'h0, 16'h0, 0);
    chk("t5.suppress", 32'(cnt), 32'h3);
    check_state("t5.asleep");
    send_frame(16'h0010, 16'h0, 0);
    chk("t5.wake", 32'(slp), 32'h0);
    chk("t5.woken_cnt", 32'(cnt), 32'h4);
    check_state("t5.awake");
    drain("t5.drain");
    chk("t5.last", rd_data, 32'h0000_0010);

    // asynchronous reset mid-word
    do_reset();
    send_frame(16'h0101, 16'h0202, 0);
    send_frame(16'h0303, 16'h0404, 0);
    check_state("t6.pre");
    partial(5, 16'hF0F0);
    rst_n = 1'b0;
    #1;
    chk("t6.valid", 32'(rd_valid), 32'h0);
    chk("t6.count", 32'(cnt), 32'h0);
    chk("t6.data", rd_data, 32'h0);
    chk("t6.flags", {28'h0, in_ready, ovf, ferr, slp}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_clear();
    @(posedge clk); #1;
    send_frame(16'hBEEF, 16'hCAFE, 0);
    chk("t6.frame", rd_data, 32'hCAFE_BEEF);
    check_state("t6.post");
    drain("t6.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
